// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl_pkg
//  Description : Shared types and constants for the nibble-serial 16-bit
//                add/subtract controller: FSM state encoding, datapath
//                widths and operation codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_add_ctrl_pkg;

    // Controller states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH       = 16;
    localparam int NIBBLE      = 4;
    localparam int NUM_NIBBLES = 4;
    localparam int IDX_W       = $clog2(NUM_NIBBLES);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : nibble_serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_adder_4bit
//  Description : Purely combinational 4-bit adder with carry-in. This is the
//                only arithmetic element of the serial controller.
//  Ports       : a[3:0], b[3:0] - addends
//                cin            - carry in
//                sum[3:0]       - a + b + cin (low 4 bits)
//                cout           - carry out of bit 3
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder_4bit
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout
);

    logic [NIBBLE:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, cin};
    assign sum  = full[NIBBLE-1:0];
    assign cout = full[NIBBLE];

endmodule : nibble_adder_4bit
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl
//  Description : 16-bit add/subtract computed one nibble per cycle through a
//                single 4-bit adder. Valid/ready handshake on both sides.
//                Accept (IDLE) -> 4 RUN cycles -> DONE, held until out_ready.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                in_valid/in_ready - operand handshake (ready only in IDLE)
//                op               - 0 = A+B, 1 = A-B
//                a, b             - 16-bit operands
//                out_valid/out_ready - result handshake (valid only in DONE)
//                result           - 16-bit sum/difference (wraps)
//                carry_out        - carry out of bit 15 (sub: 1 = no borrow)
//                overflow         - signed two's-complement overflow
//                zero             - result == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;        // B' : b, or ~b when subtracting
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    logic [NIBBLE-1:0]  nib_a;
    logic [NIBBLE-1:0]  nib_b;
    logic [NIBBLE-1:0]  nib_sum;
    logic               nib_cout;
    logic [3:0]         nib_base;

    // Bit offset of the current nibble (idx * 4).
    assign nib_base = {idx_q, 2'b00};
    assign nib_a    = a_q[nib_base +: NIBBLE];
    assign nib_b    = b_q[nib_base +: NIBBLE];

    nibble_adder_4bit u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // ------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: the op bit is folded into
                    // the inverted operand and the initial carry, so it need
                    // not be kept separately.
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = op;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                result_d[nib_base +: NIBBLE] = nib_sum;
                carry_d = nib_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_NIBBLES - 1)) begin
                    // Flags are captured on the last nibble so they stay
                    // frozen together with the result while in DONE.
                    state_d     = DONE;
                    carry_out_d = nib_cout;
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (nib_sum[NIBBLE-1] != a_q[WIDTH-1]);
                    zero_d      = (result_d == '0);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule : nibble_serial_add_ctrl
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_add_ctrl
//  Description : Self-checking bench for nibble_serial_add_ctrl: directed
//                vector table, backpressure and reset-abort sequences, and
//                random operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    nibble_serial_add_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        ov;
        logic        z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model written from the arithmetic definition, not the datapath.
    task automatic model(input logic mop, input logic [15:0] ma, input logic [15:0] mb,
                         output logic [15:0] mres, output logic mc, output logic mov, output logic mz);
        int sa, sb, sr;
        int unsigned ua, ub;
        ua = ma;
        ub = mb;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (mop) begin
            mres = 16'((ua - ub) & 32'hFFFF);
            mc   = (ua >= ub);
            sr   = sa - sb;
        end else begin
            mres = 16'((ua + ub) & 32'hFFFF);
            mc   = ((ua + ub) > 32'hFFFF);
            sr   = sa + sb;
        end
        mov = (sr > 32767) || (sr < -32768);
        mz  = (mres == 16'h0000);
    endtask

    // Accept one operation; operands are scrambled right after the accept
    // edge. Returns the edge count (accept edge = 1) at which out_valid rose.
    task automatic issue(input logic iop, input logic [15:0] ia, input logic [15:0] ib,
                         output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        op = iop; a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
        while (!out_valid && lat < 20) begin
            chk("in_ready_low_running", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL done_timeout actual=no_out_valid required=out_valid");
        end
    endtask

    task automatic check_out(input string name, input logic [15:0] er, input logic ec,
                             input logic eov, input logic ez);
        chk({name, "_result"}, {16'd0, result}, {16'd0, er});
        chk({name, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
        chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, eov});
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
        chk({name, "_in_ready_in_done"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_release", {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        logic [15:0] er, hr;
        logic ec, eov, ez, hc, hov, hz;

        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 1'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
        chk("reset_outputs", {12'd0, carry_out, overflow, zero, 1'b0, result}, 32'd0);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd5);
            check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].ov, vecs[i].z);
            release_done();
        end

        // Backpressure: hold DONE for 10 cycles while offering new operands.
        issue(1'b0, 16'h1234, 16'h4321, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_out("bp", 16'h5555, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        release_done();
        // Nothing must have been accepted while stalled in DONE.
        @(negedge clk);
        chk("bp_no_accept", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of RUN (idx = 2).
        @(negedge clk);
        op = 1'b0; a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk);                 // accept
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);      // idx 0 and 1 processed, idx = 2
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("rst_mid_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
        chk("rst_mid_outputs", {12'd0, carry_out, overflow, zero, 1'b0, result}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        issue(1'b0, 16'h0001, 16'h0001, lat);
        chk("post_rst_latency", lat, 32'd5);
        check_out("post_rst", 16'h0002, 1'b0, 1'b0, 1'b0);
        release_done();

        // Random operations against the reference model, with random DONE stalls.
        for (int i = 0; i < 40; i++) begin
            logic        rop;
            logic [15:0] ra, rb;
            int          stall;
            rop = 1'($urandom);
            ra  = 16'($urandom);
            rb  = (i % 8 == 0) ? ra : 16'($urandom);
            model(rop, ra, rb, er, ec, eov, ez);
            issue(rop, ra, rb, lat);
            chk("rand_latency", lat, 32'd5);
            check_out("rand", er, ec, eov, ez);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                chk("rand_stall_hold", {15'd0, out_valid, result}, {15'd0, 1'b1, er});
            end
            in_valid = 1'b0;
            release_done();
        end

        // Model sanity on a fixed case, compared against the DUT once more.
        model(1'b1, 16'h0000, 16'h0001, hr, hc, hov, hz);
        issue(1'b1, 16'h0000, 16'h0001, lat);
        check_out("borrow_all", hr, hc, hov, hz);
        release_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_nibble_serial_add_ctrl
`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL use one clock, `clk`; `reset` SHALL be synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- op  input  1  0 = add (A+B), 1 = subtract (A-B)
- a  input  16  operand A
- b  input  16  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  16  sum or difference
- carry_out  output  1  final carry (subtract: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  result == 0

Function
REQ-003 The block SHALL compute a 16-bit add or subtract over four cycles, one 4-bit nibble per cycle, through a single 4-bit adder with carry-in.
REQ-004 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 Acceptance SHALL occur on a rising edge with in_valid=1 in IDLE; on that edge the block SHALL latch a and op, latch b (inverted if op=1), set the carry register to op, clear the nibble index to 0 and enter RUN.
REQ-007 On each RUN edge the block SHALL add nibble[idx] of the latched A and B' with the carry register, write the sum into result[4*idx+3:4*idx], update the carry register, and increment idx.
REQ-008 On the RUN edge with idx=3 the block SHALL enter DONE, so out_valid first rises 5 edges after the accept edge (acceptance edge plus 4 RUN edges).
REQ-009 In DONE, result, carry_out, overflow and zero SHALL hold stable until the edge where out_ready=1, which SHALL return the block to IDLE.
REQ-010 overflow SHALL be (A[15]==B'[15]) && (result[15]!=A[15]); zero SHALL be (result==16'h0000).
REQ-011 All arithmetic SHALL wrap modulo 2^16; the carry out of bit 15 SHALL appear only on carry_out.
REQ-012 in_valid outside IDLE SHALL be ignored, with no latching and no state change.
REQ-013 out_ready outside DONE SHALL be ignored.
REQ-014 in_ready SHALL NOT rise in the same cycle that out_valid is high, so the minimum issue interval is 6 cycles.
REQ-015 Operand inputs SHALL be don't-care after the accept edge; changes SHALL NOT affect the result in progress.

Reset
REQ-016 While reset=1 on an edge, the state SHALL become IDLE and result, carry_out, overflow, zero, idx and the carry register SHALL become 0.
REQ-017 Immediately after that edge, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse, and reset SHALL take priority over in_valid and out_ready.

Structure
REQ-019 A shared package SHALL define:
- the state enum {IDLE, RUN, DONE}
- WIDTH=16
- NIBBLE=4
- NUM_NIBBLES=4
- OP_ADD=0 and OP_SUB=1
REQ-020 The 4-bit adder SHALL be a separate combinational sub-module, nibble_adder_4bit (inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout), instantiated once; the controller SHALL contain no other adder.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Add: a=16'h1234, b=16'h4321, op=0 → result 16'h5555, carry_out 0, overflow 0, zero 0; out_valid first high 5 edges after accept.
- Carry ripple across nibbles: a=16'hFFFF, b=16'h0001, op=0 → result 16'h0000, carry_out 1, zero 1, overflow 0.
- Signed overflow: a=16'h7FFF, b=16'h0001, op=0 → result 16'h8000, overflow 1.
- Subtract: a=16'h0005, b=16'h0007, op=1 → result 16'hFFFE, carry_out 0; and a=16'h8000, b=16'h0001, op=1 → result 16'h7FFF, overflow 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and drive in_valid=1 with new operands → outputs stable, in_ready 0, no new accept; raise out_ready → IDLE next edge.
- Reset mid-RUN: assert reset at RUN idx=2 → next cycle IDLE, all outputs 0, no out_valid; a following add of 16'h0001+16'h0001 → 16'h0002.
